// File: rtl/hesap_hakem_if.sv
// hesap_hakem_if
//   Bundles the signals around the calculator arbiter:
//   - two request channels (req0_*, req1_*): gecerli/tur/sayi1/sayi2 in, hazir out
//   - calculator channel (calc_*): start pulse and operands out, hazir/gecerli/sonuc/tasma in
//   - response channel (yanit_*): gecerli/id/sonuc/tasma/hata out, hazir in
//   - mesgul: arbiter busy indication
//   modport master: the arbiter side; modport slave: requesters, calculator and consumer.
interface hesap_hakem_if;
  logic        req0_gecerli;
  logic        req0_hazir;
  logic [2:0]  req0_tur;
  logic [31:0] req0_sayi1;
  logic [31:0] req0_sayi2;

  logic        req1_gecerli;
  logic        req1_hazir;
  logic [2:0]  req1_tur;
  logic [31:0] req1_sayi1;
  logic [31:0] req1_sayi2;

  logic        calc_basla;
  logic [2:0]  calc_tur;
  logic [31:0] calc_sayi1;
  logic [31:0] calc_sayi2;
  logic        calc_hazir;
  logic        calc_gecerli;
  logic [63:0] calc_sonuc;
  logic        calc_tasma;

  logic        yanit_gecerli;
  logic        yanit_hazir;
  logic        yanit_id;
  logic [63:0] yanit_sonuc;
  logic        yanit_tasma;
  logic        yanit_hata;

  logic        mesgul;

  modport master (
    input  req0_gecerli, req0_tur, req0_sayi1, req0_sayi2,
    output req0_hazir,
    input  req1_gecerli, req1_tur, req1_sayi1, req1_sayi2,
    output req1_hazir,
    output calc_basla, calc_tur, calc_sayi1, calc_sayi2,
    input  calc_hazir, calc_gecerli, calc_sonuc, calc_tasma,
    output yanit_gecerli, yanit_id, yanit_sonuc, yanit_tasma, yanit_hata,
    input  yanit_hazir,
    output mesgul
  );

  modport slave (
    output req0_gecerli, req0_tur, req0_sayi1, req0_sayi2,
    input  req0_hazir,
    output req1_gecerli, req1_tur, req1_sayi1, req1_sayi2,
    input  req1_hazir,
    input  calc_basla, calc_tur, calc_sayi1, calc_sayi2,
    output calc_hazir, calc_gecerli, calc_sonuc, calc_tasma,
    input  yanit_gecerli, yanit_id, yanit_sonuc, yanit_tasma, yanit_hata,
    output yanit_hazir,
    input  mesgul
  );
endinterface

// File: rtl/hesap_hakem.sv
// hesap_hakem
//   Two-port round-robin arbiter and sequencer in front of the shared calculator.
//   Accepts one request at a time, starts the calculator, waits for its result
//   (bounded by ZAMAN_ASIMI cycles) and returns it tagged with the requester id.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-low reset
//     bus  - hesap_hakem_if.master (request, calculator and response channels)
//
//   state  | meaning
//   BOS    | idle, arbitrating between requesters
//   GONDER | start pulse to the calculator
//   BEKLE  | waiting for the calculator result or timeout
//   YANIT  | response presented, waiting for the consumer
module hesap_hakem #(
  parameter int ZAMAN_ASIMI = 16,
  parameter int SAYAC_GEN   = 8
) (
  input logic           clk,
  input logic           rst,
  hesap_hakem_if.master bus
);

  typedef enum logic [1:0] {BOS, GONDER, BEKLE, YANIT} durum_t;

  localparam logic [2:0]           GECERSIZ  = 3'b111;
  localparam logic [SAYAC_GEN-1:0] SAYAC_SON = SAYAC_GEN'(ZAMAN_ASIMI - 1);

  durum_t               durum;
  logic                 son_id;
  logic [SAYAC_GEN-1:0] sayac;

  logic        calc_basla_q;
  logic [2:0]  calc_tur_q;
  logic [31:0] calc_sayi1_q;
  logic [31:0] calc_sayi2_q;
  logic        yanit_gecerli_q;
  logic        yanit_id_q;
  logic [63:0] yanit_sonuc_q;
  logic        yanit_tasma_q;
  logic        yanit_hata_q;

  logic        talep_var;
  logic        tahsis;
  logic        kabul;
  logic [2:0]  sec_tur;
  logic [31:0] sec_sayi1;
  logic [31:0] sec_sayi2;

  // A tie goes to the requester that was not served last.
  always_comb begin
    talep_var = bus.req0_gecerli | bus.req1_gecerli;
    if (bus.req0_gecerli && bus.req1_gecerli) begin
      tahsis = ~son_id;
    end else begin
      tahsis = bus.req1_gecerli;
    end
    kabul     = (durum == BOS) && bus.calc_hazir && talep_var;
    sec_tur   = tahsis ? bus.req1_tur   : bus.req0_tur;
    sec_sayi1 = tahsis ? bus.req1_sayi1 : bus.req0_sayi1;
    sec_sayi2 = tahsis ? bus.req1_sayi2 : bus.req0_sayi2;
  end

  assign bus.req0_hazir = kabul && !tahsis;
  assign bus.req1_hazir = kabul && tahsis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      durum           <= BOS;
      son_id          <= 1'b1;
      sayac           <= '0;
      calc_basla_q    <= 1'b0;
      calc_tur_q      <= '0;
      calc_sayi1_q    <= '0;
      calc_sayi2_q    <= '0;
      yanit_gecerli_q <= 1'b0;
      yanit_id_q      <= 1'b0;
      yanit_sonuc_q   <= '0;
      yanit_tasma_q   <= 1'b0;
      yanit_hata_q    <= 1'b0;
    end else begin
      case (durum)
        BOS: begin
          if (kabul) begin
            son_id       <= tahsis;
            yanit_id_q   <= tahsis;
            calc_tur_q   <= sec_tur;
            calc_sayi1_q <= sec_sayi1;
            calc_sayi2_q <= sec_sayi2;
            if (sec_tur == GECERSIZ) begin
              // Invalid opcode is answered directly, calculator stays untouched.
              yanit_gecerli_q <= 1'b1;
              yanit_hata_q    <= 1'b1;
              yanit_sonuc_q   <= '0;
              yanit_tasma_q   <= 1'b0;
              durum           <= YANIT;
            end else begin
              calc_basla_q <= 1'b1;
              durum        <= GONDER;
            end
          end
        end
        GONDER: begin
          calc_basla_q <= 1'b0;
          sayac        <= '0;
          durum        <= BEKLE;
        end
        BEKLE: begin
          // A result arriving on the expiry cycle still takes precedence.
          if (bus.calc_gecerli) begin
            yanit_gecerli_q <= 1'b1;
            yanit_sonuc_q   <= bus.calc_sonuc;
            yanit_tasma_q   <= bus.calc_tasma;
            yanit_hata_q    <= 1'b0;
            durum           <= YANIT;
          end else if (sayac == SAYAC_SON) begin
            yanit_gecerli_q <= 1'b1;
            yanit_sonuc_q   <= '0;
            yanit_tasma_q   <= 1'b0;
            yanit_hata_q    <= 1'b1;
            durum           <= YANIT;
          end else begin
            sayac <= sayac + 1'b1;
          end
        end
        YANIT: begin
          if (bus.yanit_hazir) begin
            yanit_gecerli_q <= 1'b0;
            durum           <= BOS;
          end
        end
        default: durum <= BOS;
      endcase
    end
  end

  assign bus.calc_basla    = calc_basla_q;
  assign bus.calc_tur      = calc_tur_q;
  assign bus.calc_sayi1    = calc_sayi1_q;
  assign bus.calc_sayi2    = calc_sayi2_q;
  assign bus.yanit_gecerli = yanit_gecerli_q;
  assign bus.yanit_id      = yanit_id_q;
  assign bus.yanit_sonuc   = yanit_sonuc_q;
  assign bus.yanit_tasma   = yanit_tasma_q;
  assign bus.yanit_hata    = yanit_hata_q;
  assign bus.mesgul        = (durum != BOS);

endmodule

// File: tb/tb_hesap_hakem.sv
// tb_hesap_hakem
//   Self-checking bench for hesap_hakem. The bench plays both requesters, the
//   calculator and the response consumer; expected grants, latencies and
//   response fields come from a transaction-level model of the arbitration rules.
module tb_hesap_hakem;
  localparam int ZA = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hesap_hakem_if bus ();

  hesap_hakem #(.ZAMAN_ASIMI(ZA), .SAYAC_GEN(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int vektor = 0;
  int hatali = 0;
  bit mdl_son_id = 1'b1;   // requester served last, as seen by the model

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen, input logic [63:0] beklenen);
    vektor++;
    if (gozlenen !== beklenen) begin
      hatali++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic girisleri_sifirla();
    bus.req0_gecerli = 1'b0; bus.req0_tur = '0; bus.req0_sayi1 = '0; bus.req0_sayi2 = '0;
    bus.req1_gecerli = 1'b0; bus.req1_tur = '0; bus.req1_sayi1 = '0; bus.req1_sayi2 = '0;
    bus.calc_hazir   = 1'b1; bus.calc_gecerli = 1'b0; bus.calc_sonuc = '0; bus.calc_tasma = 1'b0;
    bus.yanit_hazir  = 1'b0;
  endtask

  task automatic sifir_cikis_kontrol(input string etiket);
    kontrol({etiket, "_calc_basla"}, bus.calc_basla, 0);
    kontrol({etiket, "_calc_tur"}, bus.calc_tur, 0);
    kontrol({etiket, "_calc_sayi"}, {bus.calc_sayi1, bus.calc_sayi2}, 0);
    kontrol({etiket, "_yanit_gecerli"}, bus.yanit_gecerli, 0);
    kontrol({etiket, "_yanit_sonuc"}, bus.yanit_sonuc, 0);
    kontrol({etiket, "_yanit_bayrak"}, {bus.yanit_id, bus.yanit_tasma, bus.yanit_hata}, 0);
    kontrol({etiket, "_mesgul"}, bus.mesgul, 0);
  endtask

  // One complete transaction, entered and left on a negedge with the DUT in BOS.
  // gecikme: BEKLE cycle index at which the calculator answers (-1: never).
  task automatic islem(input bit v0, input bit v1,
                       input logic [2:0] t0, input logic [2:0] t1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1,
                       input int gecikme, input logic [63:0] sonuc, input bit tasma,
                       input int bekletme, input bit hazir_gecikmeli);
    bit g;
    bit zaman;
    int k;
    int e_k;
    logic [2:0]  e_tur;
    logic [31:0] e_a, e_b;
    logic [63:0] e_sonuc;
    bit e_tasma, e_hata;

    if (!v0 && !v1) v0 = 1'b1;
    bus.req0_gecerli = v0; bus.req0_tur = t0; bus.req0_sayi1 = a0; bus.req0_sayi2 = b0;
    bus.req1_gecerli = v1; bus.req1_tur = t1; bus.req1_sayi1 = a1; bus.req1_sayi2 = b1;

    if (hazir_gecikmeli) begin
      bus.calc_hazir = 1'b0;
      #1;
      kontrol("calc_mesgul_req0_hazir", bus.req0_hazir, 0);
      kontrol("calc_mesgul_req1_hazir", bus.req1_hazir, 0);
      @(negedge clk);
      kontrol("calc_mesgul_bos", bus.mesgul, 0);
    end
    bus.calc_hazir = 1'b1;

    g = (v0 && v1) ? !mdl_son_id : v1;
    #1;
    kontrol("req0_hazir", bus.req0_hazir, (g == 1'b0));
    kontrol("req1_hazir", bus.req1_hazir, (g == 1'b1));
    mdl_son_id = g;
    e_tur = g ? t1 : t0;
    e_a   = g ? a1 : a0;
    e_b   = g ? b1 : b0;

    @(negedge clk);
    bus.req0_gecerli = 1'b0;
    bus.req1_gecerli = 1'b0;
    kontrol("mesgul_kabul", bus.mesgul, 1);

    if (e_tur == 3'b111) begin
      kontrol("gecersiz_basla_yok", bus.calc_basla, 0);
      e_hata = 1'b1; e_sonuc = '0; e_tasma = 1'b0;
    end else begin
      kontrol("calc_basla", bus.calc_basla, 1);
      kontrol("calc_tur", bus.calc_tur, e_tur);
      kontrol("calc_sayi1", bus.calc_sayi1, e_a);
      kontrol("calc_sayi2", bus.calc_sayi2, e_b);
      @(negedge clk);
      kontrol("calc_basla_tek", bus.calc_basla, 0);
      zaman = !(gecikme >= 0 && gecikme < ZA);
      e_k   = zaman ? ZA - 1 : gecikme;
      k = 0;
      while (!bus.yanit_gecerli && k <= ZA + 1) begin
        kontrol("bekle_tur_sabit", bus.calc_tur, e_tur);
        bus.calc_gecerli = (k == gecikme);
        bus.calc_sonuc   = sonuc;
        bus.calc_tasma   = tasma;
        @(negedge clk);
        bus.calc_gecerli = 1'b0;
        k++;
      end
      kontrol("yanit_gecikme", 64'(k - 1), 64'(e_k));
      e_hata  = zaman;
      e_sonuc = zaman ? 64'd0 : sonuc;
      e_tasma = zaman ? 1'b0 : tasma;
    end

    kontrol("yanit_gecerli", bus.yanit_gecerli, 1);
    kontrol("yanit_id", bus.yanit_id, g);
    kontrol("yanit_sonuc", bus.yanit_sonuc, e_sonuc);
    kontrol("yanit_tasma", bus.yanit_tasma, e_tasma);
    kontrol("yanit_hata", bus.yanit_hata, e_hata);

    for (int i = 0; i < bekletme; i++) begin
      bus.req0_gecerli = 1'b1;
      bus.req1_gecerli = 1'b1;
      if (i == 0) begin
        // Late/stray calculator result while a response is pending.
        bus.calc_gecerli = 1'b1;
        bus.calc_sonuc   = {$urandom, $urandom};
        bus.calc_tasma   = ~e_tasma;
      end
      #1;
      kontrol("yanit_req0_hazir", bus.req0_hazir, 0);
      kontrol("yanit_req1_hazir", bus.req1_hazir, 0);
      @(negedge clk);
      bus.calc_gecerli = 1'b0;
      bus.calc_tasma   = 1'b0;
      kontrol("bp_gecerli", bus.yanit_gecerli, 1);
      kontrol("bp_sonuc", bus.yanit_sonuc, e_sonuc);
      kontrol("bp_bayrak", {bus.yanit_id, bus.yanit_tasma, bus.yanit_hata}, {g, e_tasma, e_hata});
      kontrol("bp_mesgul", bus.mesgul, 1);
    end

    bus.req0_gecerli = 1'b0;
    bus.req1_gecerli = 1'b0;
    bus.yanit_hazir  = 1'b1;
    @(negedge clk);
    bus.yanit_hazir  = 1'b0;
    kontrol("yanit_birakma", bus.yanit_gecerli, 0);
    kontrol("bos_donus", bus.mesgul, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int gk;
    girisleri_sifirla();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    sifir_cikis_kontrol("reset");
    rst = 1'b1;
    @(negedge clk);
    mdl_son_id = 1'b1;

    // Single add, calculator answers two cycles after start.
    islem(1, 0, 3'b000, 3'b000, 32'd5, 32'd7, 0, 0, 1, 64'd12, 1'b0, 0, 0);

    // Contention: both requesters held valid across four operations.
    for (int i = 0; i < 4; i++)
      islem(1, 1, 3'b000, 3'b001, $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 4), {$urandom, $urandom}, 1'($urandom), 0, 0);

    // Invalid opcode from requester 1.
    islem(0, 1, 3'b000, 3'b111, 0, 0, 32'd9, 32'd3, 0, 64'd0, 1'b0, 0, 0);

    // Timeout, with a late result pulse during the response.
    islem(1, 0, 3'b010, 3'b000, 32'd4, 32'd4, 0, 0, -1, 64'hdead, 1'b1, 2, 0);

    // Result on the exact expiry cycle wins over the timeout.
    islem(0, 1, 3'b000, 3'b011, 0, 0, 32'd8, 32'd2, ZA - 1, 64'd4, 1'b1, 0, 0);

    // Backpressure for ten cycles, calculator briefly not ready.
    islem(1, 1, 3'b100, 3'b101, 32'd16, 0, 32'd1, 0, 3, 64'd4, 1'b0, 10, 1);

    // Reset during BEKLE.
    bus.req0_gecerli = 1'b1; bus.req0_tur = 3'b000; bus.req0_sayi1 = 32'd1; bus.req0_sayi2 = 32'd2;
    @(negedge clk);
    bus.req0_gecerli = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kontrol("bekle_mesgul", bus.mesgul, 1);
    rst = 1'b0;
    #1;
    sifir_cikis_kontrol("bekle_reset");
    @(negedge clk);
    rst = 1'b1;
    mdl_son_id = 1'b1;
    bus.calc_gecerli = 1'b1;
    bus.calc_sonuc   = 64'h55;
    @(negedge clk);
    bus.calc_gecerli = 1'b0;
    kontrol("reset_sonrasi_yanit_yok", bus.yanit_gecerli, 0);
    kontrol("reset_sonrasi_bos", bus.mesgul, 0);
    islem(1, 1, 3'b001, 3'b010, 32'd10, 32'd3, 32'd6, 32'd7, 0, 64'd7, 1'b0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 9);
      gk = (r == 0) ? -1 : $urandom_range(0, ZA - 1);
      islem(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
            $urandom, $urandom, $urandom, $urandom,
            gk, {$urandom, $urandom}, 1'($urandom),
            $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vektor, hatali);
    $finish;
  end
endmodule
